lsu_port: RTL and testbench
===========================

Name: lsu_port

Overview:
- Load/store initiator that drives the data port (port B) of the byte-enabled dual-port memory on behalf of the CPU core.
- Accepts one RV32I load/store request at a time.
- Generates word address, byte-lane write enables and lane-replicated store data.
- Handles the memory's 1-cycle registered read latency, then extracts and sign/zero-extends load data back to the core.

Parameters:
- ADDR_WIDTH, 15, memory word-address width; byte address space is 2**(ADDR_WIDTH+2).
- NUM_COL, 4, byte lanes per word (fixed 4; other values unsupported).
- COL_WIDTH, 8, bits per lane.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  1  request strobe, sampled only when ready=1.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: B/H/W only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low bits significant.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: misaligned, out-of-range or illegal funct3.
- load_data  out  32  formatted load result, valid with done; held until the next done.
- mem_en  out  1  to memory enaB.
- mem_we  out  4  to memory weB.
- mem_addr  out  ADDR_WIDTH  to memory addrB (word address).
- mem_din  out  32  to memory dinB.
- mem_dout  in  32  from memory doutB (registered, 1-cycle latency).

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE; ready=1; done=0; err=0; load_data=0; mem_en=0; mem_we=0; mem_addr=0; mem_din=0.
- Reset asserted mid-operation aborts at once: mem_en/mem_we drop on the next edge and no done is issued.
- FSM states and transitions:
  - IDLE: on req, latch request, run checks → ACCESS (legal) or FAULT (illegal).
  - ACCESS: mem_en=1 and mem_we/mem_addr/mem_din driven (all registered outputs, asserted exactly this one cycle) → RESP.
  - RESP: mem_en=0; mem_dout valid; format it → DONE.
  - DONE: done=1, err=0, load_data updated (loads only; stores leave load_data unchanged) → IDLE.
  - FAULT: done=1, err=1, load_data unchanged; mem_en never asserted → IDLE.
- Latency: req accepted in cycle 0.
  - Legal access: done in cycle 3.
  - Fault: done in cycle 1.
  - Next request accepted in the cycle after done (ready high again).
- req while ready=0 is ignored and not queued.
- Checks, evaluated at acceptance:
  - H/HU with addr[0]=1 → fault.
  - W with addr[1:0]≠0 → fault.
  - req_addr[31:ADDR_WIDTH+2]≠0 → fault.
  - funct3 011/110/111 → fault.
  - Store with funct3 100/101 → fault.
- Address: mem_addr = req_addr[ADDR_WIDTH+1:2].
- Store lanes:
  - SB: mem_we = 4'b0001 << addr[1:0]; mem_din = byte replicated ×4.
  - SH: mem_we = 4'b0011 << addr[1:0]; mem_din = halfword replicated ×2.
  - SW: mem_we = 4'b1111; mem_din = wdata.
- Loads: mem_we = 4'b0000.
- Load formatting: select byte mem_dout[8*a +: 8] or halfword mem_dout[16*a[1] +: 16], where a = addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Core contract: the core holds its state in LOAD_STORE from acceptance until done; otherwise the memory ignores port B.

Decomposition:
- constant_defs.v gets:
  - funct3 defines: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - FSM state encodings: LSU_IDLE, LSU_ACCESS, LSU_RESP, LSU_DONE, LSU_FAULT.
- Sub-module lsu_align (combinational) holds:
  - store lane/replication logic.
  - load extract/extend logic.
  - legality check.
- lsu_port keeps the FSM and registers.

Test Plan:
- Word 0x100 preloaded 0x8899AABB; load B at 0x403 → mem_en in cycle 1 with mem_addr=0x100, mem_we=0000; done in cycle 3, err=0, load_data=0xFFFFFF88.
- Same word; load HU at 0x402 → load_data=0x00008899. Load H at 0x400 → 0xFFFFAABB. Load W at 0x400 → 0x8899AABB.
- Store B at 0x401, wdata=0x12345677 → mem_we=0010, mem_din=0x77777777; subsequent load W at 0x400 → 0x889977BB.
- Load H at 0x401 → done in cycle 1, err=1, mem_en stays 0, load_data unchanged. Load W at 0x00020000 (out of range) → same response.
- rst_n=0 in RESP of a load → no done; all outputs zero next cycle; ready=1 after release.
- req held high for 10 cycles with alternating SW/LW to 0x0 → requests accepted only when ready=1, one done per 4 cycles. Also: req asserted while busy is dropped.

Source files
------------

// File: rtl/lsu_port_pkg.sv
// Shared definitions for the load/store port.
// funct3 codes for RV32I loads/stores, the FSM state type, and a small
// decode helper used by the alignment logic.
package lsu_port_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_ACCESS,
    LSU_RESP,
    LSU_DONE,
    LSU_FAULT
  } lsuState_e;

  function automatic logic isHalf(input logic [2:0] funct3);
    return (funct3 == LSU_H) || (funct3 == LSU_HU);
  endfunction

endpackage

// File: rtl/lsu_port_if.sv
// Bus bundle between the core, the load/store port and memory port B.
//   Core side : req, req_store, req_funct3, req_addr, req_wdata -> LSU
//               ready, done, err, load_data                     <- LSU
//   Memory    : mem_en, mem_we, mem_addr, mem_din              <- LSU
//               mem_dout (registered, 1-cycle latency)         -> LSU
// master = core + memory environment, slave = lsu_port.
interface lsu_port_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8
);
  logic                          req;
  logic                          req_store;
  logic [2:0]                    req_funct3;
  logic [31:0]                   req_addr;
  logic [31:0]                   req_wdata;
  logic                          ready;
  logic                          done;
  logic                          err;
  logic [31:0]                   load_data;
  logic                          mem_en;
  logic [NUM_COL-1:0]            mem_we;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [NUM_COL*COL_WIDTH-1:0]  mem_din;
  logic [NUM_COL*COL_WIDTH-1:0]  mem_dout;

  modport master (
    output req, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    input  ready, done, err, load_data, mem_en, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  req, req_store, req_funct3, req_addr, req_wdata, mem_dout,
    output ready, done, err, load_data, mem_en, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/lsu_port_align.sv
// lsu_align: combinational datapath of the load/store port.
//   chk*  : request legality check plus store lane enables / replicated data
//   fmt*  : byte/halfword extraction and sign/zero extension of read data
module lsu_align
  import lsu_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8
) (
  input  logic                         chkStore,
  input  logic [2:0]                   chkFunct3,
  input  logic [31:0]                  chkAddr,
  input  logic [31:0]                  chkWdata,
  output logic                         chkLegal,
  output logic [NUM_COL-1:0]           stWe,
  output logic [NUM_COL*COL_WIDTH-1:0] stDin,
  input  logic [2:0]                   fmtFunct3,
  input  logic [1:0]                   fmtLane,
  input  logic [NUM_COL*COL_WIDTH-1:0] fmtRdata,
  output logic [31:0]                  fmtData
);

  localparam int unsigned DW = NUM_COL * COL_WIDTH;

  logic                   badFunct3;
  logic                   badStore;
  logic                   halfMis;
  logic                   wordMis;
  logic                   outOfRange;
  logic [COL_WIDTH-1:0]   byteSel;
  logic [2*COL_WIDTH-1:0] halfSel;

  always_comb begin
    badFunct3  = chkFunct3 inside {3'b011, 3'b110, 3'b111};
    badStore   = chkStore & chkFunct3[2];
    halfMis    = isHalf(chkFunct3) & chkAddr[0];
    wordMis    = (chkFunct3 == LSU_W) & (chkAddr[1:0] != 2'b00);
    outOfRange = (chkAddr >> (ADDR_WIDTH + 2)) != '0;
    chkLegal   = !(badFunct3 | badStore | halfMis | wordMis | outOfRange);
  end

  // Lane enables and data only matter for legal stores; loads write nothing.
  always_comb begin
    stWe  = '0;
    stDin = '0;
    if (chkStore) begin
      case (chkFunct3)
        LSU_B: begin
          stWe  = NUM_COL'(4'b0001) << chkAddr[1:0];
          stDin = {NUM_COL{chkWdata[COL_WIDTH-1:0]}};
        end
        LSU_H: begin
          stWe  = NUM_COL'(4'b0011) << chkAddr[1:0];
          stDin = {(NUM_COL/2){chkWdata[2*COL_WIDTH-1:0]}};
        end
        LSU_W: begin
          stWe  = '1;
          stDin = DW'(chkWdata);
        end
        default: begin
          stWe  = '0;
          stDin = '0;
        end
      endcase
    end
  end

  always_comb begin
    byteSel = fmtRdata[COL_WIDTH*fmtLane +: COL_WIDTH];
    halfSel = fmtRdata[2*COL_WIDTH*fmtLane[1] +: 2*COL_WIDTH];
    case (fmtFunct3)
      LSU_B:   fmtData = {{(32-COL_WIDTH){byteSel[COL_WIDTH-1]}}, byteSel};
      LSU_BU:  fmtData = {{(32-COL_WIDTH){1'b0}}, byteSel};
      LSU_H:   fmtData = {{(32-2*COL_WIDTH){halfSel[2*COL_WIDTH-1]}}, halfSel};
      LSU_HU:  fmtData = {{(32-2*COL_WIDTH){1'b0}}, halfSel};
      default: fmtData = 32'(fmtRdata);
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// lsu_port: drives port B of the byte-enabled dual-port memory for the core.
// One load/store at a time: IDLE -> ACCESS -> RESP -> DONE (legal) or
// IDLE -> FAULT (illegal). All bus outputs except ready are registered.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : lsu_port_if.slave (core request/response + memory port B)
module lsu_port
  import lsu_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned NUM_COL    = 4,
  parameter int unsigned COL_WIDTH  = 8
) (
  input logic       clk,
  input logic       rst_n,
  lsu_port_if.slave bus
);

  localparam int unsigned DW = NUM_COL * COL_WIDTH;

  lsuState_e             state, stateNext;
  logic                  storeQ, storeD;
  logic [2:0]            funct3Q, funct3D;
  logic [1:0]            laneQ, laneD;
  logic                  memEnQ, memEnD;
  logic [NUM_COL-1:0]    memWeQ, memWeD;
  logic [ADDR_WIDTH-1:0] memAddrQ, memAddrD;
  logic [DW-1:0]         memDinQ, memDinD;
  logic                  doneQ, doneD;
  logic                  errQ, errD;
  logic [31:0]           loadDataQ, loadDataD;

  logic                  legal;
  logic [NUM_COL-1:0]    alignWe;
  logic [DW-1:0]         alignDin;
  logic [31:0]           fmtData;

  lsu_align #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH)
  ) u_align (
    .chkStore (bus.req_store),
    .chkFunct3(bus.req_funct3),
    .chkAddr  (bus.req_addr),
    .chkWdata (bus.req_wdata),
    .chkLegal (legal),
    .stWe     (alignWe),
    .stDin    (alignDin),
    .fmtFunct3(funct3Q),
    .fmtLane  (laneQ),
    .fmtRdata (bus.mem_dout),
    .fmtData  (fmtData)
  );

  // Output register inputs are computed alongside the next state so that
  // mem_en/done line up with ACCESS/DONE/FAULT exactly one cycle each.
  always_comb begin
    stateNext = state;
    storeD    = storeQ;
    funct3D   = funct3Q;
    laneD     = laneQ;
    memEnD    = 1'b0;
    memWeD    = '0;
    memAddrD  = memAddrQ;
    memDinD   = memDinQ;
    doneD     = 1'b0;
    errD      = 1'b0;
    loadDataD = loadDataQ;
    case (state)
      LSU_IDLE: begin
        if (bus.req) begin
          storeD  = bus.req_store;
          funct3D = bus.req_funct3;
          laneD   = bus.req_addr[1:0];
          if (legal) begin
            stateNext = LSU_ACCESS;
            memEnD    = 1'b1;
            memWeD    = alignWe;
            memAddrD  = bus.req_addr[ADDR_WIDTH+1:2];
            memDinD   = alignDin;
          end else begin
            stateNext = LSU_FAULT;
            doneD     = 1'b1;
            errD      = 1'b1;
          end
        end
      end
      LSU_ACCESS: stateNext = LSU_RESP;
      LSU_RESP: begin
        stateNext = LSU_DONE;
        doneD     = 1'b1;
        if (!storeQ) loadDataD = fmtData;
      end
      LSU_DONE:  stateNext = LSU_IDLE;
      LSU_FAULT: stateNext = LSU_IDLE;
      default:   stateNext = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LSU_IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      storeQ    <= 1'b0;
      funct3Q   <= '0;
      laneQ     <= '0;
      memEnQ    <= 1'b0;
      memWeQ    <= '0;
      memAddrQ  <= '0;
      memDinQ   <= '0;
      doneQ     <= 1'b0;
      errQ      <= 1'b0;
      loadDataQ <= '0;
    end else begin
      storeQ    <= storeD;
      funct3Q   <= funct3D;
      laneQ     <= laneD;
      memEnQ    <= memEnD;
      memWeQ    <= memWeD;
      memAddrQ  <= memAddrD;
      memDinQ   <= memDinD;
      doneQ     <= doneD;
      errQ      <= errD;
      loadDataQ <= loadDataD;
    end
  end

  assign bus.ready     = (state == LSU_IDLE);
  assign bus.done      = doneQ;
  assign bus.err       = errQ;
  assign bus.load_data = loadDataQ;
  assign bus.mem_en    = memEnQ;
  assign bus.mem_we    = memWeQ;
  assign bus.mem_addr  = memAddrQ;
  assign bus.mem_din   = memDinQ;

endmodule

// File: tb/tb_lsu_port.sv
// Self-checking bench for lsu_port: a registered byte-enabled memory model
// on port B, a vector table of requests, and scoreboard queues of expected
// memory accesses and done responses checked at the falling clock edge.
module tb_lsu_port;
  import lsu_port_pkg::*;

  localparam int unsigned AW = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_port_if #(.ADDR_WIDTH(AW), .NUM_COL(4), .COL_WIDTH(8)) bus ();

  lsu_port #(.ADDR_WIDTH(AW), .NUM_COL(4), .COL_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Port B memory model: read-first, registered output.
  logic [31:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
    mem[32'h100] <= 32'h8899AABB;
  end
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      bus.mem_dout <= mem[bus.mem_addr];
      for (int i = 0; i < 4; i++)
        if (bus.mem_we[i]) mem[bus.mem_addr][8*i +: 8] <= bus.mem_din[8*i +: 8];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        expErr;
    logic [3:0]  expWe;
    logic [31:0] expDin;
    logic [31:0] expData;
  } vec_t;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  we;
    logic [14:0] addr;
    logic [31:0] din;
    logic        chkDin;
  } memExp_t;

  typedef struct {
    int unsigned cyc;
    logic        err;
    logic [31:0] data;
  } doneExp_t;

  memExp_t  memQ[$];
  doneExp_t doneQ[$];
  vec_t     vecs[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor: every mem_en and every done must match a queued expectation.
  always @(negedge clk) begin : mon
    memExp_t  m;
    doneExp_t d;
    if (bus.mem_en === 1'b1) begin
      if (memQ.size() == 0) flagFail("unexpected_mem_en");
      else begin
        m = memQ.pop_front();
        chk("mem_cycle", 32'(cyc), 32'(m.cyc));
        chk("mem_we", 32'(bus.mem_we), 32'(m.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
        if (m.chkDin) chk("mem_din", bus.mem_din, m.din);
      end
    end
    if (bus.done === 1'b1) begin
      if (doneQ.size() == 0) flagFail("unexpected_done");
      else begin
        d = doneQ.pop_front();
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
        chk("err", 32'(bus.err), 32'(d.err));
        chk("load_data", bus.load_data, d.data);
      end
    end
  end

  // Called at a falling edge; drives one request for exactly one cycle
  // once ready, queuing the expected access and response.
  task automatic issue(input vec_t v);
    int unsigned n;
    memExp_t     m;
    doneExp_t    d;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) flagFail("ready_timeout");
    bus.req        = 1'b1;
    bus.req_store  = v.st;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wd;
    if (!v.expErr) begin
      m.cyc    = cyc + 1;
      m.we     = v.expWe;
      m.addr   = v.addr[16:2];
      m.din    = v.expDin;
      m.chkDin = v.st;
      memQ.push_back(m);
    end
    d.cyc  = cyc + (v.expErr ? 1 : 3);
    d.err  = v.expErr;
    d.data = v.expData;
    doneQ.push_back(d);
    @(negedge clk);
    bus.req = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((doneQ.size() != 0 || memQ.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (doneQ.size() != 0 || memQ.size() != 0) begin
      flagFail("drain_timeout");
      doneQ.delete();
      memQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stim
    int unsigned idx;
    logic [31:0] lastWd;
    vec_t        v;

    bus.req        = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    // {st, f3, addr, wdata, expErr, expWe, expDin, expLoadData}
    vecs.push_back('{1'b0, LSU_B,  32'h403,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFF88});
    vecs.push_back('{1'b0, LSU_HU, 32'h402,      32'h0,        1'b0, 4'b0000, 32'h0,        32'h00008899});
    vecs.push_back('{1'b0, LSU_H,  32'h400,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFAABB});
    vecs.push_back('{1'b0, LSU_W,  32'h400,      32'h0,        1'b0, 4'b0000, 32'h0,        32'h8899AABB});
    vecs.push_back('{1'b0, LSU_BU, 32'h401,      32'h0,        1'b0, 4'b0000, 32'h0,        32'h000000AA});
    vecs.push_back('{1'b1, LSU_B,  32'h401,      32'h12345677, 1'b0, 4'b0010, 32'h77777777, 32'h000000AA});
    vecs.push_back('{1'b0, LSU_W,  32'h400,      32'h0,        1'b0, 4'b0000, 32'h0,        32'h889977BB});
    vecs.push_back('{1'b1, LSU_H,  32'h402,      32'h0000CAFE, 1'b0, 4'b1100, 32'hCAFECAFE, 32'h889977BB});
    vecs.push_back('{1'b0, LSU_H,  32'h402,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFCAFE});
    vecs.push_back('{1'b0, LSU_B,  32'h400,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFBB});
    vecs.push_back('{1'b1, LSU_W,  32'h404,      32'hDEADBEEF, 1'b0, 4'b1111, 32'hDEADBEEF, 32'hFFFFFFBB});
    vecs.push_back('{1'b0, LSU_W,  32'h404,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, LSU_H,  32'h401,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, LSU_W,  32'h00020000, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, LSU_W,  32'h402,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'b011, 32'h400,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b1, LSU_BU, 32'h400,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b1, LSU_HU, 32'h400,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'b111, 32'h400,      32'h0,        1'b1, 4'b0000, 32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, LSU_BU, 32'h0001FFFF, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h00000000});
    vecs.push_back('{1'b0, LSU_HU, 32'h406,      32'h0,        1'b0, 4'b0000, 32'h0,        32'h0000DEAD});
    vecs.push_back('{1'b0, LSU_B,  32'h407,      32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFDE});
    vecs.push_back('{1'b1, LSU_B,  32'h0001FFFF, 32'h000000A5, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFFDE});
    vecs.push_back('{1'b0, LSU_B,  32'h0001FFFF, 32'h0,        1'b0, 4'b0000, 32'h0,        32'hFFFFFFA5});
    vecs.push_back('{1'b1, LSU_W,  32'h406,      32'h11111111, 1'b1, 4'b0000, 32'h0,        32'hFFFFFFA5});
    vecs.push_back('{1'b0, LSU_B,  32'h80000000, 32'h0,        1'b1, 4'b0000, 32'h0,        32'hFFFFFFA5});

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready",     32'(bus.ready),    32'h1);
    chk("rst_done",      32'(bus.done),     32'h0);
    chk("rst_err",       32'(bus.err),      32'h0);
    chk("rst_load_data", bus.load_data,     32'h0);
    chk("rst_mem_en",    32'(bus.mem_en),   32'h0);
    chk("rst_mem_we",    32'(bus.mem_we),   32'h0);
    chk("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("rst_mem_din",   bus.mem_din,       32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      issue(vecs[i]);
      drain();
    end

    // Request while busy is dropped: the store to word 0 must never happen.
    issue('{1'b0, LSU_W, 32'h400, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hCAFE77BB});
    chk("busy_ready", 32'(bus.ready), 32'h0);
    bus.req        = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = LSU_W;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'hFFFFFFFF;
    @(negedge clk);
    bus.req = 1'b0;
    drain();
    issue('{1'b0, LSU_W, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h00000000});
    drain();

    // Reset during RESP of a load: no done, everything cleared.
    issue('{1'b0, LSU_H, 32'h404, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hFFFFBEEF});
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    doneQ.delete();
    chk("abort_done",      32'(bus.done),     32'h0);
    chk("abort_err",       32'(bus.err),      32'h0);
    chk("abort_mem_en",    32'(bus.mem_en),   32'h0);
    chk("abort_mem_we",    32'(bus.mem_we),   32'h0);
    chk("abort_mem_addr",  32'(bus.mem_addr), 32'h0);
    chk("abort_mem_din",   bus.mem_din,       32'h0);
    chk("abort_load_data", bus.load_data,     32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.ready), 32'h1);
    repeat (4) @(negedge clk);
    issue('{1'b0, LSU_W, 32'h404, 32'h0, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF});
    drain();

    // req held high: alternating SW/LW to 0x0, accepted only while ready.
    idx    = 0;
    lastWd = 32'h0;
    for (int k = 0; k < 24; k++) begin
      if (bus.ready === 1'b1) begin
        if (idx % 2 == 0) begin
          lastWd = 32'hA5000000 | 32'(idx);
          v = '{1'b1, LSU_W, 32'h0, lastWd, 1'b0, 4'b1111, lastWd, 32'hDEADBEEF};
          if (idx > 0) v.expData = 32'hA5000000 | 32'(idx - 2);
        end else begin
          v = '{1'b0, LSU_W, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, lastWd};
        end
        bus.req        = 1'b1;
        bus.req_store  = v.st;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wd;
        memQ.push_back('{cyc + 1, v.expWe, v.addr[16:2], v.expDin, v.st});
        doneQ.push_back('{cyc + 3, 1'b0, v.expData});
        idx++;
      end
      @(negedge clk);
    end
    bus.req = 1'b0;
    chk("burst_accepts", 32'(idx), 32'd6);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
